// File: rtl/thresh_job_ctrl.sv
// Job sequencer for the thresholding pipeline: loads SRAM_P, pulses the core
// reset and start, waits on a watchdog, then drains SRAM_B to the host.
module thresh_job_ctrl #(
  parameter int P_WORDS = 32768,
  parameter int B_BYTES = 131072,
  parameter int TIMEOUT = 1048576
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic        Abort,
  input  logic        Ld_Valid,
  input  logic [31:0] Ld_Data,
  output logic        Ld_Ready,
  input  logic        Rd_Ready,
  output logic        Rd_Valid,
  output logic [7:0]  Rd_Data,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic        Rst_Core,
  output logic        Go_t,
  input  logic        Done_t,
  output logic [14:0] MP_Addr15,
  output logic [31:0] MP_di31,
  output logic        MP_enb,
  output logic        MP_web,
  output logic [16:0] MB_Addr17_2,
  output logic        MB_ena,
  output logic        MB_wea,
  input  logic [7:0]  MB_do8_2
);

  localparam int WW = (P_WORDS > 1) ? $clog2(P_WORDS) : 1;
  localparam int BW = $clog2(B_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] LAST_WORD = WW'(P_WORDS - 1);
  localparam logic [BW-1:0] ALL_BYTES = BW'(B_BYTES);
  localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CRST, S_GO, S_WAIT, S_READ, S_DONE, S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   word_cnt_q, word_cnt_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            ld_ready_q, ld_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            rst_core_q, rst_core_d;
  logic            go_q, go_d;
  logic            mp_en_q, mp_en_d;
  logic [14:0]     mp_addr_q, mp_addr_d;
  logic [31:0]     mp_data_q, mp_data_d;
  logic            mb_ena_q, mb_ena_d;
  logic [16:0]     mb_addr_q, mb_addr_d;
  logic            rd_valid_q, rd_valid_d;
  logic            load_hs, rd_issue;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    load_hs    = ld_ready_q & Ld_Valid;
    rd_issue   = (state_q == S_READ) & Rd_Ready & (byte_cnt_q != ALL_BYTES);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_d    = S_LOAD;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          wd_cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (load_hs) begin
          word_cnt_d = word_cnt_q + WW'(1);
          if (word_cnt_q == LAST_WORD) state_d = S_CRST;
        end
      end
      S_CRST: state_d = S_GO;
      S_GO:   state_d = S_WAIT;
      S_WAIT: begin
        // Done_t is tested first so it wins over a simultaneous expiry.
        if (Done_t)                    state_d = S_READ;
        else if (wd_cnt_q == WD_LAST)  state_d = S_ERR;
        else                           wd_cnt_d = wd_cnt_q + TW'(1);
      end
      S_READ: begin
        if (rd_issue) byte_cnt_d = byte_cnt_q + BW'(1);
        if (rd_valid_q && !mb_ena_q && byte_cnt_q == ALL_BYTES) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (Abort) state_d = S_IDLE;

    // Outputs are registered decodes of the next state, so they line up with state_q.
    ld_ready_d = (state_d == S_LOAD);
    busy_d     = !(state_d inside {S_IDLE, S_DONE, S_ERR});
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    rst_core_d = (state_d == S_CRST);
    go_d       = (state_d == S_GO) || (state_d == S_WAIT);
    mp_en_d    = load_hs & ~Abort;
    mp_addr_d  = load_hs ? 15'(word_cnt_q) : mp_addr_q;
    mp_data_d  = load_hs ? Ld_Data : mp_data_q;
    mb_ena_d   = rd_issue & ~Abort;
    mb_addr_d  = rd_issue ? 17'(byte_cnt_q) : mb_addr_q;
    rd_valid_d = mb_ena_q & ~Abort;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      wd_cnt_q   <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rst_core_q <= 1'b0;
      go_q       <= 1'b0;
      mp_en_q    <= 1'b0;
      mp_addr_q  <= '0;
      mp_data_q  <= '0;
      mb_ena_q   <= 1'b0;
      mb_addr_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rst_core_q <= rst_core_d;
      go_q       <= go_d;
      mp_en_q    <= mp_en_d;
      mp_addr_q  <= mp_addr_d;
      mp_data_q  <= mp_data_d;
      mb_ena_q   <= mb_ena_d;
      mb_addr_q  <= mb_addr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign Ld_Ready    = ld_ready_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Err         = err_q;
  assign Rst_Core    = rst_core_q;
  assign Go_t        = go_q;
  assign MP_Addr15   = mp_addr_q;
  assign MP_di31     = mp_data_q;
  assign MP_enb      = mp_en_q;
  assign MP_web      = mp_en_q;
  assign MB_Addr17_2 = mb_addr_q;
  assign MB_ena      = mb_ena_q;
  assign MB_wea      = 1'b0;
  assign Rd_Valid    = rd_valid_q;
  // SRAM_B's own output register supplies the data; gating keeps it 0 when not valid.
  assign Rd_Data     = rd_valid_q ? MB_do8_2 : 8'h00;

endmodule

// File: tb/tb_thresh_job_ctrl.sv
// Directed bench for thresh_job_ctrl with small parameters, an SRAM_B read
// model and monitors logging SRAM_P writes, SRAM_B issues and result bytes.
module tb_thresh_job_ctrl;

  localparam int P_WORDS = 4;
  localparam int B_BYTES = 8;
  localparam int TIMEOUT = 16;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic        Ld_Valid = 1'b0;
  logic [31:0] Ld_Data = '0;
  logic        Ld_Ready;
  logic        Rd_Ready = 1'b0;
  logic        Rd_Valid;
  logic [7:0]  Rd_Data;
  logic        Busy, Done, Err, Rst_Core, Go_t;
  logic        Done_t = 1'b0;
  logic [14:0] MP_Addr15;
  logic [31:0] MP_di31;
  logic        MP_enb, MP_web;
  logic [16:0] MB_Addr17_2;
  logic        MB_ena, MB_wea;
  logic [7:0]  MB_do8_2 = 8'h5A;

  thresh_job_ctrl #(.P_WORDS(P_WORDS), .B_BYTES(B_BYTES), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort),
    .Ld_Valid(Ld_Valid), .Ld_Data(Ld_Data), .Ld_Ready(Ld_Ready),
    .Rd_Ready(Rd_Ready), .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data),
    .Busy(Busy), .Done(Done), .Err(Err), .Rst_Core(Rst_Core), .Go_t(Go_t),
    .Done_t(Done_t), .MP_Addr15(MP_Addr15), .MP_di31(MP_di31),
    .MP_enb(MP_enb), .MP_web(MP_web), .MB_Addr17_2(MB_Addr17_2),
    .MB_ena(MB_ena), .MB_wea(MB_wea), .MB_do8_2(MB_do8_2)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int inv_bad = 0;

  logic [31:0] words_a [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0] words_b [4] = '{32'hDEADBEEF, 32'h0BADF00D, 32'h12345678, 32'hCAFEF00D};
  logic [7:0]  mem_b   [8] = '{8'h3C, 8'hA5, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12, 8'hC9};

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          iss_addr[$];
  int          iss_cyc[$];
  logic [7:0]  rv_data[$];
  int          rv_cyc[$];

  logic [82:0] all_outs;
  assign all_outs = {Ld_Ready, Rd_Valid, Rd_Data, Busy, Done, Err, Rst_Core, Go_t,
                     MP_Addr15, MP_di31, MP_enb, MP_web, MB_Addr17_2, MB_ena, MB_wea};

  // SRAM_B port A: one-cycle synchronous read.
  always @(posedge Clk) if (MB_ena) MB_do8_2 <= mem_b[MB_Addr17_2[2:0]];

  always @(posedge Clk) begin
    if (Rst_n) begin
      if (MP_enb) begin
        wr_addr.push_back(int'(MP_Addr15));
        wr_data.push_back(MP_di31);
        wr_cyc.push_back(cyc);
      end
      if (MB_ena) begin
        iss_addr.push_back(int'(MB_Addr17_2));
        iss_cyc.push_back(cyc);
      end
      if (Rd_Valid) begin
        rv_data.push_back(Rd_Data);
        rv_cyc.push_back(cyc);
      end
      if (MP_enb !== MP_web || MB_wea !== 1'b0) inv_bad <= inv_bad + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    iss_addr.delete(); iss_cyc.delete();
    rv_data.delete(); rv_cyc.delete();
  endtask

  task automatic start_and_load(input bit use_b);
    Start = 1'b1; tick(); Start = 1'b0;
    Ld_Valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Ld_Data = use_b ? words_b[i] : words_a[i];
      tick();
    end
    Ld_Valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL reset_async got=%h exp=0", all_outs);
    end
    tick(); tick();
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL reset_held got=%h exp=0", all_outs);
    end
    Rst_n = 1'b1;
    tick();
    checks++;
    if ({Busy, Ld_Ready, Done, Err} !== 4'b0000) begin
      errors++; $display("FAIL reset_idle got=%b exp=0000", {Busy, Ld_Ready, Done, Err});
    end
  endtask

  task automatic test_basic_job();
    int done_cyc;
    clear_logs();
    Start = 1'b1; tick(); Start = 1'b0;
    checks++;
    if ({Busy, Ld_Ready} !== 2'b11) begin
      errors++; $display("FAIL start_busy_ready got=%b exp=11", {Busy, Ld_Ready});
    end
    Ld_Valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Ld_Data = words_a[i];
      tick();
    end
    Ld_Valid = 1'b0;
    checks++;
    if ({Ld_Ready, Rst_Core, Go_t, MP_enb} !== 4'b0101) begin
      errors++; $display("FAIL last_write_crst got=%b exp=0101", {Ld_Ready, Rst_Core, Go_t, MP_enb});
    end
    tick();
    checks++;
    if ({Rst_Core, Go_t} !== 2'b01) begin
      errors++; $display("FAIL go_phase got=%b exp=01", {Rst_Core, Go_t});
    end
    tick();
    checks++;
    if ({Busy, Go_t} !== 2'b11) begin
      errors++; $display("FAIL wait_go got=%b exp=11", {Busy, Go_t});
    end
    checks++;
    if (wr_addr.size() != 4) begin
      errors++; $display("FAIL basic_write_count got=%0d exp=4", wr_addr.size());
    end
    for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
      checks++;
      if (wr_addr[i] != i || wr_data[i] !== words_a[i] || wr_cyc[i] != wr_cyc[0] + i) begin
        errors++;
        $display("FAIL basic_write%0d got=a%0d d%h c+%0d exp=a%0d d%h c+%0d",
                 i, wr_addr[i], wr_data[i], wr_cyc[i] - wr_cyc[0], i, words_a[i], i);
      end
    end
    repeat (9) tick();
    Done_t = 1'b1; tick(); Done_t = 1'b0;
    checks++;
    if ({Busy, Go_t} !== 2'b10) begin
      errors++; $display("FAIL done_t_drops_go got=%b exp=10", {Busy, Go_t});
    end
    Rd_Ready = 1'b1;
    done_cyc = -1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (Done) begin done_cyc = cyc; break; end
    end
    Rd_Ready = 1'b0;
    checks++;
    if (done_cyc < 0 || rv_data.size() != 8) begin
      errors++; $display("FAIL basic_done got=cyc%0d bytes%0d exp=done with 8 bytes", done_cyc, rv_data.size());
    end
    for (int i = 0; i < rv_data.size() && i < 8; i++) begin
      checks++;
      if (rv_data[i] !== mem_b[i] || iss_addr[i] != i || rv_cyc[i] != iss_cyc[i] + 1 ||
          (i > 0 && iss_cyc[i] != iss_cyc[i-1] + 1)) begin
        errors++;
        $display("FAIL basic_byte%0d got=%h addr%0d lat%0d exp=%h addr%0d lat1",
                 i, rv_data[i], iss_addr[i], rv_cyc[i] - iss_cyc[i], mem_b[i], i);
      end
    end
    if (rv_cyc.size() == 8) begin
      checks++;
      if (done_cyc != rv_cyc[7] + 1 || Busy !== 1'b0) begin
        errors++; $display("FAIL basic_done_timing got=+%0d busy%b exp=+1 busy0", done_cyc - rv_cyc[7], Busy);
      end
    end
  endtask

  task automatic test_toggle_load_timeout();
    int idx, rst_cyc, err_cyc;
    logic rdy;
    clear_logs();
    Start = 1'b1; tick(); Start = 1'b0;
    checks++;
    if ({Done, Ld_Ready} !== 2'b01) begin
      errors++; $display("FAIL restart_clears_done got=%b exp=01", {Done, Ld_Ready});
    end
    idx = 0;
    for (int t = 0; t < 20 && idx < 4; t++) begin
      Ld_Valid = (t % 2 == 0);
      Ld_Data  = words_b[idx];
      rdy = Ld_Ready;
      tick();
      if (Ld_Valid && rdy) idx++;
    end
    Ld_Valid = 1'b0;
    rst_cyc = cyc;
    checks++;
    if (Rst_Core !== 1'b1) begin
      errors++; $display("FAIL toggle_crst got=%b exp=1", Rst_Core);
    end
    err_cyc = -1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (Err) begin err_cyc = cyc; break; end
    end
    checks++;
    if (err_cyc != rst_cyc + 2 + TIMEOUT) begin
      errors++; $display("FAIL watchdog_timing got=%0d exp=%0d cycles after WAIT entry", err_cyc - rst_cyc - 2, TIMEOUT);
    end
    checks++;
    if ({Go_t, Busy, Done} !== 3'b000) begin
      errors++; $display("FAIL err_outputs got=%b exp=000", {Go_t, Busy, Done});
    end
    tick();
    checks++;
    if (Err !== 1'b1) begin
      errors++; $display("FAIL err_level got=%b exp=1", Err);
    end
    checks++;
    if (wr_addr.size() != 4) begin
      errors++; $display("FAIL toggle_write_count got=%0d exp=4", wr_addr.size());
    end
    for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
      checks++;
      if (wr_addr[i] != i || wr_data[i] !== words_b[i] || wr_cyc[i] != wr_cyc[0] + 2 * i) begin
        errors++;
        $display("FAIL toggle_write%0d got=a%0d d%h c+%0d exp=a%0d d%h c+%0d",
                 i, wr_addr[i], wr_data[i], wr_cyc[i] - wr_cyc[0], i, words_b[i], 2 * i);
      end
    end
    Start = 1'b1; tick(); Start = 1'b0;
    checks++;
    if ({Err, Busy, Ld_Ready} !== 3'b011) begin
      errors++; $display("FAIL start_clears_err got=%b exp=011", {Err, Busy, Ld_Ready});
    end
  endtask

  task automatic test_start_ignored_throttled_read();
    int done_cyc;
    clear_logs();
    Ld_Valid = 1'b1;
    Ld_Data = words_a[0]; tick();
    Ld_Data = words_a[1]; tick();
    Ld_Valid = 1'b0;
    Start = 1'b1; tick(); Start = 1'b0;
    checks++;
    if ({Busy, Ld_Ready} !== 2'b11) begin
      errors++; $display("FAIL start_in_load got=%b exp=11", {Busy, Ld_Ready});
    end
    Ld_Valid = 1'b1;
    Ld_Data = words_a[2]; tick();
    Ld_Data = words_a[3]; tick();
    Ld_Valid = 1'b0;
    checks++;
    if (Rst_Core !== 1'b1) begin
      errors++; $display("FAIL ignored_start_crst got=%b exp=1", Rst_Core);
    end
    tick(); tick();
    checks++;
    if (wr_addr.size() != 4) begin
      errors++; $display("FAIL ignored_start_writes got=%0d exp=4", wr_addr.size());
    end
    for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
      checks++;
      if (wr_addr[i] != i || wr_data[i] !== words_a[i]) begin
        errors++; $display("FAIL ignored_start_write%0d got=a%0d d%h exp=a%0d d%h", i, wr_addr[i], wr_data[i], i, words_a[i]);
      end
    end
    Done_t = 1'b1; tick(); Done_t = 1'b0;
    done_cyc = -1;
    for (int t = 0; t < 80; t++) begin
      Rd_Ready = (t % 3 == 0);
      tick();
      if (Done) begin done_cyc = cyc; break; end
    end
    Rd_Ready = 1'b0;
    checks++;
    if (done_cyc < 0 || rv_data.size() != 8 || iss_addr.size() != 8) begin
      errors++; $display("FAIL throttle_done got=cyc%0d bytes%0d issues%0d exp=done 8 8", done_cyc, rv_data.size(), iss_addr.size());
    end
    for (int i = 0; i < rv_data.size() && i < 8 && i < iss_addr.size(); i++) begin
      checks++;
      if (rv_data[i] !== mem_b[i] || iss_addr[i] != i || rv_cyc[i] != iss_cyc[i] + 1 ||
          (i > 0 && iss_cyc[i] != iss_cyc[i-1] + 3)) begin
        errors++;
        $display("FAIL throttle_byte%0d got=%h addr%0d lat%0d exp=%h addr%0d lat1",
                 i, rv_data[i], iss_addr[i], rv_cyc[i] - iss_cyc[i], mem_b[i], i);
      end
    end
    if (rv_cyc.size() == 8) begin
      checks++;
      if (done_cyc != rv_cyc[7] + 1) begin
        errors++; $display("FAIL throttle_done_timing got=+%0d exp=+1", done_cyc - rv_cyc[7]);
      end
    end
  endtask

  task automatic test_abort_wait();
    start_and_load(1'b0);
    repeat (5) tick();
    checks++;
    if (Go_t !== 1'b1) begin
      errors++; $display("FAIL abort_wait_pre got=%b exp=1", Go_t);
    end
    Abort = 1'b1; tick(); Abort = 1'b0;
    checks++;
    if ({Busy, Go_t, Rst_Core, Ld_Ready, MP_enb, MB_ena, Rd_Valid, Done, Err} !== 9'b0) begin
      errors++;
      $display("FAIL abort_wait_outs got=%b exp=000000000",
               {Busy, Go_t, Rst_Core, Ld_Ready, MP_enb, MB_ena, Rd_Valid, Done, Err});
    end
    repeat (20) tick();
    checks++;
    if ({Err, Busy, Go_t} !== 3'b000) begin
      errors++; $display("FAIL abort_wait_stays_idle got=%b exp=000", {Err, Busy, Go_t});
    end
  endtask

  task automatic test_abort_read();
    int n_before;
    bit found;
    clear_logs();
    start_and_load(1'b1);
    tick(); tick();
    Done_t = 1'b1; tick(); Done_t = 1'b0;
    Rd_Ready = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (MB_ena && Rd_Valid) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL abort_read_inflight got=none exp=read in flight");
    end
    n_before = rv_data.size();
    Abort = 1'b1; tick(); Abort = 1'b0;
    Rd_Ready = 1'b0;
    checks++;
    if ({Rd_Valid, MB_ena, Busy, Done, Err, Go_t} !== 6'b0) begin
      errors++; $display("FAIL abort_read_outs got=%b exp=000000", {Rd_Valid, MB_ena, Busy, Done, Err, Go_t});
    end
    repeat (3) tick();
    checks++;
    if (rv_data.size() != n_before + 1) begin
      errors++; $display("FAIL abort_read_no_valid got=%0d exp=%0d", rv_data.size(), n_before + 1);
    end
  endtask

  task automatic test_async_reset_mid_load();
    Start = 1'b1; tick(); Start = 1'b0;
    Ld_Valid = 1'b1;
    Ld_Data = words_b[0]; tick();
    Ld_Data = words_b[1]; tick();
    Ld_Valid = 1'b0;
    checks++;
    if ({Ld_Ready, MP_enb} !== 2'b11) begin
      errors++; $display("FAIL midload_pre got=%b exp=11", {Ld_Ready, MP_enb});
    end
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL midload_async_reset got=%h exp=0", all_outs);
    end
    #2 Rst_n = 1'b1;
    tick();
    checks++;
    if ({Busy, Ld_Ready} !== 2'b00) begin
      errors++; $display("FAIL midload_idle got=%b exp=00", {Busy, Ld_Ready});
    end
    Start = 1'b1; tick(); Start = 1'b0;
    checks++;
    if ({Busy, Ld_Ready} !== 2'b11) begin
      errors++; $display("FAIL post_reset_start got=%b exp=11", {Busy, Ld_Ready});
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (inv_bad != 0) begin
      errors++; $display("FAIL port_invariants got=%0d bad cycles exp=0", inv_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_toggle_load_timeout();
    test_start_ignored_throttled_read();
    test_abort_wait();
    test_abort_read();
    test_async_reset_mid_load();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=no finish exp=finish");
    $fatal(1, "bench time limit");
  end

endmodule
